// File: rtl/net_strength_resolver_pkg.sv
// Shared encodings for the net strength resolver: strengths, 4-state values, FSM states.
// Also a small max helper used when merging driver strengths.
package net_strength_resolver_pkg;

  localparam logic [2:0] ST_HIGHZ  = 3'd0;
  localparam logic [2:0] ST_SMALL  = 3'd1;
  localparam logic [2:0] ST_MEDIUM = 3'd2;
  localparam logic [2:0] ST_WEAK   = 3'd3;
  localparam logic [2:0] ST_LARGE  = 3'd4;
  localparam logic [2:0] ST_PULL   = 3'd5;
  localparam logic [2:0] ST_STRONG = 3'd6;
  localparam logic [2:0] ST_SUPPLY = 3'd7;

  localparam logic [1:0] V_0 = 2'b00;
  localparam logic [1:0] V_1 = 2'b01;
  localparam logic [1:0] V_X = 2'b10;
  localparam logic [1:0] V_Z = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_e;

  function automatic logic [2:0] str_max(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/net_strength_resolver_combine.sv
// Merges one driver record into the running (max0,max1) pair and resolves the merged pair.
// Purely combinational; the resolved value reflects the record being merged.
module net_strength_resolver_combine
  import net_strength_resolver_pkg::*;
(
  input  logic       rec_en,
  input  logic [1:0] rec_val,
  input  logic [2:0] rec_s0,
  input  logic [2:0] rec_s1,
  input  logic [2:0] max0_i,
  input  logic [2:0] max1_i,
  output logic [2:0] max0_o,
  output logic [2:0] max1_o,
  output logic [1:0] res_val,
  output logic [2:0] res_str,
  output logic       res_conflict
);

  always_comb begin
    max0_o = max0_i;
    max1_o = max1_i;
    if (rec_en) begin
      unique case (rec_val)
        V_0: max0_o = str_max(max0_i, rec_s0);
        V_1: max1_o = str_max(max1_i, rec_s1);
        V_X: begin
          max0_o = str_max(max0_i, rec_s0);
          max1_o = str_max(max1_i, rec_s1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    res_val      = V_Z;
    res_str      = ST_HIGHZ;
    res_conflict = 1'b0;
    if (max0_o > max1_o) begin
      res_val = V_0;
      res_str = max0_o;
    end else if (max1_o > max0_o) begin
      res_val = V_1;
      res_str = max1_o;
    end else if (max0_o != ST_HIGHZ) begin
      // Equal nonzero strengths on both sides fight to x.
      res_val      = V_X;
      res_str      = max0_o;
      res_conflict = 1'b1;
    end
  end

endmodule

// File: rtl/net_strength_resolver.sv
// Resolves a frame of per-driver records into one 4-state value + strength; result registered, held until accepted.
// Optional NET_STRENGTH_RESOLVER_CONFLICT_CNT_EN adds a saturating count of equal-strength x results.
module net_strength_resolver
  import net_strength_resolver_pkg::*;
#(
  parameter int NET_ID_W    = 8,
  parameter int MAX_DRIVERS = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NET_ID_W-1:0] in_net_id,
  input  logic [1:0]          in_val,
  input  logic [2:0]          in_s0,
  input  logic [2:0]          in_s1,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NET_ID_W-1:0] out_net_id,
  output logic [1:0]          out_val,
  output logic [2:0]          out_str,
  output logic                out_err,
  output logic [CNT_W-1:0]    conflict_cnt
);

  localparam int REC_W = $clog2(MAX_DRIVERS + 2);
  localparam logic [REC_W-1:0] REC_MAX = REC_W'(MAX_DRIVERS);
  localparam logic [REC_W-1:0] REC_SAT = REC_W'(MAX_DRIVERS + 1);

  state_e              state_q, state_d;
  logic [2:0]          max0_q, max0_d, max1_q, max1_d;
  logic [REC_W-1:0]    cnt_q, cnt_d;
  logic [NET_ID_W-1:0] id_q, id_d;
  logic                err_q, err_d;
  logic [NET_ID_W-1:0] out_net_id_q, out_net_id_d;
  logic [1:0]          out_val_q, out_val_d;
  logic [2:0]          out_str_q, out_str_d;
  logic                out_err_q, out_err_d;

  logic       accept, first, rec_err, emit_entry;
  logic [2:0] max0_m, max1_m, res_str;
  logic [1:0] res_val;
  logic       res_conflict;

  net_strength_resolver_combine u_combine (
    .rec_en       (accept),
    .rec_val      (in_val),
    .rec_s0       (in_s0),
    .rec_s1       (in_s1),
    .max0_i       (max0_q),
    .max1_i       (max1_q),
    .max0_o       (max0_m),
    .max1_o       (max1_m),
    .res_val      (res_val),
    .res_str      (res_str),
    .res_conflict (res_conflict)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_ACCUM: if (accept) state_d = in_last ? S_EMIT : S_ACCUM;
      S_EMIT:          if (out_ready) state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != S_EMIT);
    out_valid = (state_q == S_EMIT);
  end

  assign accept     = in_valid && in_ready;
  assign first      = (state_q == S_IDLE);
  assign emit_entry = accept && in_last;
  // Accumulators are zero in IDLE, so only id and count need first-record handling.
  assign rec_err    = (!first && (in_net_id != id_q)) || (cnt_q >= REC_MAX);

  always_comb begin
    max0_d       = max0_q;
    max1_d       = max1_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    err_d        = err_q;
    out_net_id_d = out_net_id_q;
    out_val_d    = out_val_q;
    out_str_d    = out_str_q;
    out_err_d    = out_err_q;
    if (accept) begin
      max0_d = max0_m;
      max1_d = max1_m;
      cnt_d  = (cnt_q == REC_SAT) ? cnt_q : cnt_q + 1'b1;
      id_d   = first ? in_net_id : id_q;
      err_d  = err_q | rec_err;
      if (in_last) begin
        out_net_id_d = first ? in_net_id : id_q;
        out_val_d    = res_val;
        out_str_d    = res_str;
        out_err_d    = err_q | rec_err;
      end
    end else if (out_valid && out_ready) begin
      max0_d = ST_HIGHZ;
      max1_d = ST_HIGHZ;
      cnt_d  = '0;
      id_d   = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max0_q       <= ST_HIGHZ;
      max1_q       <= ST_HIGHZ;
      cnt_q        <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
      out_net_id_q <= '0;
      out_val_q    <= V_Z;
      out_str_q    <= ST_HIGHZ;
      out_err_q    <= 1'b0;
    end else begin
      max0_q       <= max0_d;
      max1_q       <= max1_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      err_q        <= err_d;
      out_net_id_q <= out_net_id_d;
      out_val_q    <= out_val_d;
      out_str_q    <= out_str_d;
      out_err_q    <= out_err_d;
    end
  end

  assign out_net_id = out_net_id_q;
  assign out_val    = out_val_q;
  assign out_str    = out_str_q;
  assign out_err    = out_err_q;

`ifdef NET_STRENGTH_RESOLVER_CONFLICT_CNT_EN
  logic [CNT_W-1:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (emit_entry && res_conflict && (conflict_q != {CNT_W{1'b1}}))
      conflict_d = conflict_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_q <= '0;
    else        conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`else
  logic unused_conflict;
  assign unused_conflict = emit_entry ^ res_conflict;
  assign conflict_cnt    = '0;
`endif

endmodule

// File: tb/tb_net_strength_resolver.sv
// Bench for net_strength_resolver: directed frames then random frames against a frame-level reference model.
module tb_net_strength_resolver;

  localparam int NET_ID_W    = 8;
  localparam int MAX_DRIVERS = 16;
  localparam int CNT_W       = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid, in_ready, in_last;
  logic [NET_ID_W-1:0] in_net_id;
  logic [1:0]          in_val;
  logic [2:0]          in_s0, in_s1;
  logic                out_valid, out_ready, out_err;
  logic [NET_ID_W-1:0] out_net_id;
  logic [1:0]          out_val;
  logic [2:0]          out_str;
  logic [CNT_W-1:0]    conflict_cnt;

  int checks = 0;
  int errors = 0;

  int       fr_n;
  logic [7:0] fr_id [32];
  logic [1:0] fr_val[32];
  logic [2:0] fr_s0 [32];
  logic [2:0] fr_s1 [32];
  int         exp_conflict = 0;

  always #5 clk = ~clk;

  net_strength_resolver #(
    .NET_ID_W(NET_ID_W), .MAX_DRIVERS(MAX_DRIVERS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_net_id(in_net_id),
    .in_val(in_val), .in_s0(in_s0), .in_s1(in_s1), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_net_id(out_net_id),
    .out_val(out_val), .out_str(out_str), .out_err(out_err),
    .conflict_cnt(conflict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rec(input int i, input logic [7:0] id, input logic [1:0] v,
                         input logic [2:0] s0, input logic [2:0] s1);
    fr_id[i] = id; fr_val[i] = v; fr_s0[i] = s0; fr_s1[i] = s1;
  endtask

  // Frame-level reference: strongest driver per side, then compare sides.
  task automatic model(output logic [1:0] v, output logic [2:0] s, output logic e, output logic c);
    int m0, m1;
    m0 = 0; m1 = 0; e = (fr_n > MAX_DRIVERS); c = 1'b0;
    for (int i = 0; i < fr_n; i++) begin
      if (fr_val[i] == 2'd0 || fr_val[i] == 2'd2) m0 = (fr_s0[i] > m0) ? fr_s0[i] : m0;
      if (fr_val[i] == 2'd1 || fr_val[i] == 2'd2) m1 = (fr_s1[i] > m1) ? fr_s1[i] : m1;
      if (fr_id[i] != fr_id[0]) e = 1'b1;
    end
    if (m0 > m1)       begin v = 2'd0; s = 3'(m0); end
    else if (m1 > m0)  begin v = 2'd1; s = 3'(m1); end
    else if (m0 == 0)  begin v = 2'd3; s = 3'd0; end
    else               begin v = 2'd2; s = 3'(m0); c = 1'b1; end
  endtask

  task automatic drive_records(input int n, input logic last_on_end);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in_net_id = fr_id[i];
      in_val    = fr_val[i];
      in_s0     = fr_s0[i];
      in_s1     = fr_s1[i];
      in_last   = last_on_end && (i == n - 1);
      check("in_ready_accum", in_ready, 1'b1);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int hold);
    logic [1:0] ev; logic [2:0] es; logic ee, ec;
    logic [1:0] v0; logic [2:0] s0;
    model(ev, es, ee, ec);
    drive_records(fr_n, 1'b1);
`ifdef NET_STRENGTH_RESOLVER_CONFLICT_CNT_EN
    if (ec && exp_conflict < (1 << CNT_W) - 1) exp_conflict++;
`endif
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_val"},   out_val, ev);
    check({tag, "_str"},   out_str, es);
    check({tag, "_err"},   out_err, ee);
    check({tag, "_id"},    out_net_id, fr_id[0]);
    check({tag, "_conf"},  conflict_cnt, exp_conflict);
    v0 = out_val; s0 = out_str;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_rdy"},   in_ready, 1'b0);
      check({tag, "_hold_val"},   {out_val, out_str}, {v0, s0});
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done_valid"}, out_valid, 1'b0);
    check({tag, "_done_rdy"},   in_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   in_ready, 1'b1);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_id"},    out_net_id, 0);
    check({tag, "_val"},   out_val, 2'b11);
    check({tag, "_str"},   out_str, 0);
    check({tag, "_err"},   out_err, 0);
    check({tag, "_conf"},  conflict_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_net_id = '0;
    in_val = 2'b11; in_s0 = '0; in_s1 = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fr_n = 3;
    set_rec(0, 8'h11, 2'd1, 3'd0, 3'd7);
    set_rec(1, 8'h11, 2'd0, 3'd6, 3'd0);
    set_rec(2, 8'h11, 2'd1, 3'd0, 3'd3);
    run_frame("t1", 0);

    fr_n = 2;
    set_rec(0, 8'h22, 2'd0, 3'd6, 3'd0);
    set_rec(1, 8'h22, 2'd1, 3'd0, 3'd6);
    run_frame("t2", 0);

    fr_n = 2;
    set_rec(0, 8'h33, 2'd3, 3'd5, 3'd5);
    set_rec(1, 8'h33, 2'd3, 3'd7, 3'd2);
    run_frame("t3z", 1);

    fr_n = 1;
    set_rec(0, 8'h34, 2'd2, 3'd5, 3'd3);
    run_frame("t3x", 5);

    fr_n = 17;
    for (int i = 0; i < 17; i++) set_rec(i, 8'h44, 2'd0, 3'(i % 5), 3'd0);
    run_frame("t5ovf", 0);

    fr_n = 2;
    set_rec(0, 8'h03, 2'd1, 3'd0, 3'd4);
    set_rec(1, 8'h04, 2'd0, 3'd2, 3'd0);
    run_frame("t5id", 2);

    fr_n = 16;
    for (int i = 0; i < 16; i++) set_rec(i, 8'h45, 2'd1, 3'd0, 3'd1);
    run_frame("t5max", 0);

    // Abandon a frame mid-accumulation with a supply-strength 0 in flight.
    fr_n = 3;
    for (int i = 0; i < 3; i++) set_rec(i, 8'h55, 2'd0, 3'd7, 3'd0);
    drive_records(3, 1'b0);
    rst_n = 1'b0;
    exp_conflict = 0;
    #1;
    check_reset_outputs("t6rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fr_n = 1;
    set_rec(0, 8'h56, 2'd1, 3'd0, 3'd2);
    run_frame("t6post", 0);

    for (int f = 0; f < 60; f++) begin
      logic [7:0] base;
      fr_n = $urandom_range(1, 20);
      base = 8'($urandom);
      for (int i = 0; i < fr_n; i++) begin
        set_rec(i, ($urandom_range(0, 19) == 0) ? base ^ 8'h5a : base,
                2'($urandom), 3'($urandom), 3'($urandom));
      end
      run_frame("rnd", $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
